// File: rtl/hyper_rd_capture_pkg.sv
// Shared HyperRAM sequencer definitions: FSM encodings, the RWDS strobe
// code and the default strobe-wait budget (also used by the write side).
package hyper_rd_capture_pkg;

    // Capture sequencer states, 2-bit encoded
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_DS = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    // {rwds_ris, rwds_fal} pattern that marks a valid data beat
    localparam logic [1:0] RWDS_STRB = 2'b10;

    // Default number of strobe-free cycles tolerated before giving up
    localparam int DEF_MAX_WAIT = 32;

    // Timer width: MAX_WAIT is limited to 255
    localparam int TMO_W = 8;

    // True when the registered RWDS pair carries a data beat
    function automatic logic rwds_is_strb(input logic ris, input logic fal);
        return ({ris, fal} == RWDS_STRB);
    endfunction

endpackage

// File: rtl/hyper_rd_capture_if.sv
// Bundle between the IDDR bank / controller and the read capture sequencer.
//
// Handshake semantics: `start` is a one-cycle request that is only taken
// while `busy` is low (busy acts as the inverse of ready; a start seen while
// busy is dropped, not stalled). `rd_rdy` is a one-cycle valid for `rd_d`
// with no backpressure: the consumer must take the word in that cycle.
// `done` and `timeout` are mutually exclusive one-cycle burst terminators.
interface hyper_rd_capture_if
    import hyper_rd_capture_pkg::*;
#(
    parameter int LEN_W = 8
);
    // request side
    logic             start;
    logic [LEN_W-1:0] rd_len;
    logic             abort;

    // registered IDDR outputs
    logic [7:0]       dq_ris;
    logic [7:0]       dq_fal;
    logic             rwds_ris;
    logic             rwds_fal;

    // read-return side
    logic             busy;
    logic [15:0]      rd_d;
    logic             rd_rdy;
    logic             done;
    logic             timeout;
    logic [LEN_W-1:0] word_cnt;

    // current sequencer state for observation
    state_t           state_dbg;

    modport master (
        output start, rd_len, abort, dq_ris, dq_fal, rwds_ris, rwds_fal,
        input  busy, rd_d, rd_rdy, done, timeout, word_cnt, state_dbg
    );

    modport slave (
        input  start, rd_len, abort, dq_ris, dq_fal, rwds_ris, rwds_fal,
        output busy, rd_d, rd_rdy, done, timeout, word_cnt, state_dbg
    );

endinterface

// File: rtl/hyper_rd_capture_tmo_cnt.sv
// Loadable down-counter used as a strobe-wait watchdog. `load` wins over
// `dec`; the count sticks at zero instead of wrapping.
module hyper_tmo_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // reload on request, otherwise count down and hold at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hyper_rd_capture.sv
// HyperRAM read-data capture sequencer. Watches the registered IDDR outputs
// for RWDS data strobes after a start request, assembles 16-bit words and
// counts them to the requested length, ending in `done`, `timeout` or abort.
module hyper_rd_capture
    import hyper_rd_capture_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int LEN_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    hyper_rd_capture_if.slave bus
);

    // Timer is loaded with MAX_WAIT-1 so that the expiry decision lands in
    // the MAX_WAIT-th strobe-free cycle, leaving that same cycle open for a
    // late strobe to win.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(MAX_WAIT - 1);

    state_t           state;
    state_t           state_nxt;

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] word_cnt_q;
    logic [15:0]      rd_d_q;
    logic             rd_rdy_q;

    logic             strb;
    logic             full;
    logic             accept;
    logic             capture;
    logic             tmo_load;
    logic             tmo_dec;
    logic             tmo_zero;
    logic             timeout_c;

    assign strb = rwds_is_strb(bus.rwds_ris, bus.rwds_fal);

    // All requested words have been delivered (word_cnt updates together
    // with rd_rdy, so this is seen one cycle after the last strobe and puts
    // `done` one cycle after the last `rd_rdy`).
    assign full = (word_cnt_q == len_q);

    hyper_tmo_cnt #(
        .W (TMO_W)
    ) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .load     (tmo_load),
        .load_val (TMO_LOAD),
        .dec      (tmo_dec),
        .zero     (tmo_zero)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state and per-cycle control; priority in the wait states is
    // abort > burst complete > strobe > timer expiry
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        tmo_load  = 1'b0;
        tmo_dec   = 1'b0;
        timeout_c = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    if (bus.rd_len != '0) begin
                        tmo_load  = 1'b1;
                        state_nxt = ST_WAIT_DS;
                    end else begin
                        state_nxt = ST_FINISH;
                    end
                end
            end

            ST_WAIT_DS: begin
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                end else if (strb) begin
                    capture   = 1'b1;
                    tmo_load  = 1'b1;
                    state_nxt = ST_CAPTURE;
                end else if (tmo_zero) begin
                    timeout_c = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    tmo_dec = 1'b1;
                end
            end

            ST_CAPTURE: begin
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                end else if (full) begin
                    // surplus strobes after the last word are dropped
                    state_nxt = ST_FINISH;
                end else if (strb) begin
                    capture  = 1'b1;
                    tmo_load = 1'b1;
                end else if (tmo_zero) begin
                    timeout_c = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    tmo_dec = 1'b1;
                end
            end

            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // burst length, word counter and the registered read-return word
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            rd_d_q     <= 16'h0000;
            rd_rdy_q   <= 1'b0;
        end else begin
            rd_rdy_q <= capture;
            if (accept) begin
                len_q      <= bus.rd_len;
                word_cnt_q <= '0;
            end
            if (capture) begin
                rd_d_q <= {bus.dq_ris, bus.dq_fal};
                if (word_cnt_q != len_q) begin
                    word_cnt_q <= word_cnt_q + LEN_W'(1);
                end
            end
        end
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_FINISH);
    assign bus.timeout   = timeout_c;
    assign bus.rd_d      = rd_d_q;
    assign bus.rd_rdy    = rd_rdy_q;
    assign bus.word_cnt  = word_cnt_q;
    assign bus.state_dbg = state;

endmodule

// File: doc/hyper_rd_capture.md
# hyper_rd_capture

Read-data capture sequencer for the HyperRAM controller. It consumes the registered DDR outputs of the nine `xil_iddr` input flops: eight DQ bits and RWDS, all in SAME_EDGE_PIPELINED mode. On a start pulse it waits for the first RWDS data strobe, assembles 16-bit words, and counts them out to the requested burst length. A burst ends in a done pulse, or in a timeout pulse if RWDS stalls. It sits between the IDDR bank and the controller's read-return path.

## Interface
- `MAX_WAIT`, 32: cycles allowed without a valid strobe (initial latency and inter-word gap) before timeout; 2..255.
- `LEN_W`, 8: width of the burst-length request and word counter.
- `clk`  in  1: fabric clock, same clock driving the IDDRs; single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to capture a burst; sampled only in IDLE.
- `rd_len`  in  LEN_W: number of 16-bit words to capture; sampled with `start`.
- `abort`  in  1: terminate an in-progress burst immediately.
- `dq_ris`  in  8: IDDR rising-edge outputs of DQ[7:0].
- `dq_fal`  in  8: IDDR falling-edge outputs of DQ[7:0].
- `rwds_ris`  in  1: IDDR rising-edge output of RWDS.
- `rwds_fal`  in  1: IDDR falling-edge output of RWDS.
- `busy`  out  1: high from the cycle after accepted `start` until return to IDLE.
- `rd_d`  out  16: captured word.
- `rd_rdy`  out  1: one-cycle qualifier for `rd_d`.
- `done`  out  1: one-cycle pulse, burst completed.
- `timeout`  out  1: one-cycle pulse, strobe wait expired.
- `word_cnt`  out  LEN_W: words delivered in the current or last burst.

## Operation
- States: IDLE, WAIT_DS, CAPTURE, FINISH.
- Strobe: `strb = rwds_ris & ~rwds_fal` (RWDS high on rise, low on fall). Any other RWDS pair carries no data.
- Word: `rd_d = {dq_ris, dq_fal}`. The first byte on the bus is [15:8].
- IDLE, `start`=1, `rd_len`≠0:
  - latch `rd_len`; clear `word_cnt`; load timer with MAX_WAIT; go to WAIT_DS.
- IDLE, `start`=1, `rd_len`=0:
  - go to FINISH; no capture.
- WAIT_DS:
  - `strb`: capture the word; go to CAPTURE (or FINISH if length is 1).
  - no `strb`: decrement the timer.
  - timer reaches 0: pulse `timeout`; go to IDLE.
- CAPTURE:
  - each `strb` captures a word, increments `word_cnt` and reloads the timer.
  - the word making `word_cnt == rd_len` moves to FINISH.
  - no `strb`: decrement the timer; expiry pulses `timeout` and returns to IDLE. `word_cnt` keeps the partial count.
- FINISH: pulse `done`; return to IDLE the next cycle.
- `abort` in WAIT_DS or CAPTURE: go to IDLE next cycle, no `done`/`timeout`; `word_cnt` holds.
- `start` while not IDLE is ignored.
- Strobes arriving in IDLE or FINISH are discarded.
- Simultaneous events:
  - a strobe in the same cycle the timer would expire wins: the word is captured and no timeout occurs.
  - `abort` with a strobe: abort wins and the word is dropped.
  - `reset` overrides everything.
- Counters saturate internally. `word_cnt` never exceeds `rd_len`; width is LEN_W with no wrap.

## Timing
- Reset values: `busy`=0, `rd_rdy`=0, `done`=0, `timeout`=0, `rd_d`=16'h0000, `word_cnt`=0; state IDLE.
- Reset mid-burst: next cycle all outputs are at reset values and the state is IDLE.
- `rd_d` and `rd_rdy` are registered: they appear one clk after the IDDR outputs carrying `strb`. `rd_d` holds its last value when `rd_rdy`=0.
- `done` asserts one cycle after the last `rd_rdy`.
- `busy`:
  - rises one cycle after `start`.
  - falls in the cycle after `done`, `timeout` or `abort`.
- The earliest possible next `start` is accepted in the first cycle `busy`=0.
- Timeout fires exactly MAX_WAIT strobe-free cycles after entering WAIT_DS or after the last strobe.
- Back-to-back strobes give one `rd_rdy` per clk, with no bubbles.

## Structure
- A shared `hyper_pkg` include holds:
  - state encodings (2-bit);
  - the RWDS strobe code (2'b10);
  - the default MAX_WAIT constant, also used by the write-side sequencer.
- One natural sub-module, `hyper_tmo_cnt`: a loadable down-counter with `load`, `dec`, `zero` outputs. It is reused by the write path.
- IDDR instances stay in the I/O wrapper and are not inside this block.

## Test plan
- `rd_len`=4; strobes with DQ pairs (A5,5A),(01,02),(03,04),(FF,00) after 6 idle cycles → `rd_d` = A55A, 0102, 0304, FF00 on consecutive cycles; `done` one cycle after the last; `word_cnt`=4.
- `rd_len`=3; no RWDS for MAX_WAIT=32 cycles → `timeout` pulse at cycle 32 after entry; no `rd_rdy`; `busy` drops the next cycle.
- `rd_len`=8; 3 words, then a 20-cycle gap, then 5 words → 8 `rd_rdy`, `done`, no timeout. Repeat with a 32-cycle gap → `timeout`, `word_cnt`=3.
- `rd_len`=0 → `done` one cycle after `start`, `rd_rdy` never asserted. A `start` during any busy burst is ignored; `word_cnt` unchanged.
- `abort` coincident with the 2nd strobe of `rd_len`=5 → exactly 1 `rd_rdy`; no `done`/`timeout`; IDLE next cycle.
- `reset` asserted mid-CAPTURE, then a new `rd_len`=2 burst → all outputs 0 on the cycle after reset; the new burst delivers 2 words and `done` normally. RWDS pairs 11/01/00 never produce `rd_rdy`.
